// File: rtl/regfile_pkg.sv
// regfile_pkg
// Purpose: constants and types shared by the register file and its scoreboard.
//   XLEN     - data width of one register
//   NREGS    - number of architectural registers
//   AW       - register index width, log2(NREGS)
//   REG_ZERO - index of the hardwired-zero register x0
//   reg_idx_t - register index type
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef logic [AW-1:0] reg_idx_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Purpose: per-register pending-write tracker. Decode sets a bit at issue and
// the writeback write clears it; the two busy lookups see a same-cycle write
// as already satisfying the hazard, since the read path forwards that data.
// Ports:
//   i_clk, i_reset           - clock, synchronous active-high reset
//   i_write, i_write_reg     - writeback write (clears the busy bit)
//   i_issue, i_issue_reg     - decode issue (sets the busy bit)
//   i_sel1, i_sel2           - registers being looked up
//   o_busy1, o_busy2         - combinational busy flags for i_sel1 / i_sel2
module regfile_scoreboard #(
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int AW    = regfile_pkg::AW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_write,
  input  logic [AW-1:0] i_write_reg,
  input  logic          i_issue,
  input  logic [AW-1:0] i_issue_reg,
  input  logic [AW-1:0] i_sel1,
  input  logic [AW-1:0] i_sel2,
  output logic          o_busy1,
  output logic          o_busy2
);
  import regfile_pkg::*;

  localparam logic [AW-1:0] W_ZERO = AW'(REG_ZERO);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;
  logic             w_hit1;
  logic             w_hit2;

  // Next busy vector: an issue outranks a clear of the same register, because
  // the newly issued producer is still outstanding. x0 is never tracked.
  always_comb begin
    w_busy_next = r_busy;
    for (int i = 0; i < NREGS; i++) begin
      if (i == 0) begin
        w_busy_next[i] = 1'b0;
      end else if (i_issue && (i_issue_reg == AW'(i))) begin
        w_busy_next[i] = 1'b1;
      end else if (i_write && (i_write_reg == AW'(i))) begin
        w_busy_next[i] = 1'b0;
      end else begin
        w_busy_next[i] = r_busy[i];
      end
    end
  end

  // Busy vector register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy <= {NREGS{1'b0}};
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // A write in this very cycle satisfies the hazard via the forward path.
  assign w_hit1  = i_write && (i_write_reg == i_sel1);
  assign w_hit2  = i_write && (i_write_reg == i_sel2);
  assign o_busy1 = r_busy[i_sel1] && !w_hit1 && (i_sel1 != W_ZERO);
  assign o_busy2 = r_busy[i_sel2] && !w_hit2 && (i_sel2 != W_ZERO);

endmodule : regfile_scoreboard

// File: rtl/regfile.sv
// regfile
// Purpose: integer register file between writeback and decode. One write port,
// two registered read ports with write-through forwarding, x0 hardwired to 0,
// and a pending-write scoreboard (regfile_scoreboard).
// Ports:
//   clock, reset                   - clock, synchronous active-high reset
//   io_write/_reg/_data            - writeback write port
//   io_read_en                     - capture enable for both read ports
//   io_read_sel1/2, io_read_data1/2 - read addresses and registered read data
//   io_issue, io_issue_reg         - decode issue marking a destination busy
//   io_busy1/2                     - pending-write flags for io_read_sel1/2
module regfile #(
  parameter int XLEN  = regfile_pkg::XLEN,
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int AW    = regfile_pkg::AW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_write,
  input  logic [AW-1:0]   io_write_reg,
  input  logic [XLEN-1:0] io_write_data,
  input  logic            io_read_en,
  input  logic [AW-1:0]   io_read_sel1,
  input  logic [AW-1:0]   io_read_sel2,
  output logic [XLEN-1:0] io_read_data1,
  output logic [XLEN-1:0] io_read_data2,
  input  logic            io_issue,
  input  logic [AW-1:0]   io_issue_reg,
  output logic            io_busy1,
  output logic            io_busy2
);
  import regfile_pkg::*;

  localparam logic [AW-1:0] W_ZERO = AW'(REG_ZERO);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [XLEN-1:0] r_read_data1;
  logic [XLEN-1:0] r_read_data2;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;
  logic            w_wr_en;

  // Value a read port captures: zero for x0, else the in-flight write if it
  // targets the same register, else the stored array entry.
  function automatic logic [XLEN-1:0] f_port_value(
    input logic [AW-1:0]   sel,
    input logic [XLEN-1:0] arr_val,
    input logic            wr,
    input logic [AW-1:0]   wr_reg,
    input logic [XLEN-1:0] wr_data
  );
    logic [XLEN-1:0] v;
    if (sel == W_ZERO) begin
      v = {XLEN{1'b0}};
    end else if (wr && (wr_reg == sel)) begin
      v = wr_data;
    end else begin
      v = arr_val;
    end
    return v;
  endfunction

  assign w_wr_en = io_write && (io_write_reg != W_ZERO);

  // Forward muxes for both read ports.
  always_comb begin
    w_fwd1 = f_port_value(io_read_sel1, r_regs[io_read_sel1],
                          io_write, io_write_reg, io_write_data);
    w_fwd2 = f_port_value(io_read_sel2, r_regs[io_read_sel2],
                          io_write, io_write_reg, io_write_data);
  end

  // Data array and read capture registers; reset wins over write and capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
      r_read_data1 <= {XLEN{1'b0}};
      r_read_data2 <= {XLEN{1'b0}};
    end else begin
      if (w_wr_en) begin
        r_regs[io_write_reg] <= io_write_data;
      end
      if (io_read_en) begin
        r_read_data1 <= w_fwd1;
        r_read_data2 <= w_fwd2;
      end
    end
  end

  assign io_read_data1 = r_read_data1;
  assign io_read_data2 = r_read_data2;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .i_clk       (clock),
    .i_reset     (reset),
    .i_write     (io_write),
    .i_write_reg (io_write_reg),
    .i_issue     (io_issue),
    .i_issue_reg (io_issue_reg),
    .i_sel1      (io_read_sel1),
    .i_sel2      (io_read_sel2),
    .o_busy1     (io_busy1),
    .o_busy2     (io_busy2)
  );

endmodule : regfile

// File: doc/regfile.md
# regfile

Integer register file that terminates the writeback stage's write port: it accepts the one-per-cycle register write and serves two registered read ports to decode. It also keeps a per-register pending-write scoreboard. Decode marks a destination busy at issue, and the matching writeback write clears it. It sits between the writeback and decode stages of the single-cycle/pipelined BRISC-V core.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers.
- AW, 5, register address width, log2(NREGS).

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- io_write  in  1  register write enable from writeback.
- io_write_reg  in  AW  destination register of the write.
- io_write_data  in  XLEN  data to write.
- io_read_en  in  1  capture enable for both read ports.
- io_read_sel1  in  AW  read port 1 address.
- io_read_sel2  in  AW  read port 2 address.
- io_read_data1  out  XLEN  registered read port 1 data.
- io_read_data2  out  XLEN  registered read port 2 data.
- io_issue  in  1  decode issued an instruction that will write io_issue_reg.
- io_issue_reg  in  AW  destination register being issued.
- io_busy1  out  1  register io_read_sel1 has a pending write not yet satisfied.
- io_busy2  out  1  register io_read_sel2 has a pending write not yet satisfied.

## Operation
- x0 is hardwired to zero:
  - writes to x0 are dropped;
  - reads of x0 return 0;
  - x0 is never busy;
  - issue to x0 is ignored.
- Write: at an edge with io_write=1 and io_write_reg!=0, regs[io_write_reg] <= io_write_data.
- Read capture: at an edge with io_read_en=1, each port n loads:
  - 0 if selN==0;
  - else io_write_data if io_write=1 and io_write_reg==selN (write-through forward);
  - else regs[selN].
- Read hold: with io_read_en=0, both read data outputs hold their values.
- Scoreboard: NREGS-bit vector busy[].
  - Set: io_issue=1 and io_issue_reg!=0 sets busy[io_issue_reg].
  - Clear: io_write=1 clears busy[io_write_reg].
  - Set and clear on the same register in the same cycle: set wins, because the newer producer is outstanding.
  - Clear of a non-busy register: no effect, no error.
- Busy outputs are combinational: io_busyN = busy[selN] && !(io_write && io_write_reg==selN) && selN!=0. A same-cycle write satisfies the hazard through the forward path.
- Reset: all regs, both read data outputs and all busy bits go to 0. Reset has priority over write, issue and read capture in the same cycle.

## Timing
- Read latency: 1 cycle from the sel/en edge to io_read_dataN.
- Write to array: visible to a direct array read on the next cycle; a read captured in the same cycle sees it via the forward path.
- Busy: set becomes visible on io_busyN the cycle after issue; clear is visible combinationally in the cycle of the write.
- Reset values: io_read_data1=0, io_read_data2=0, io_busy1=0, io_busy2=0.
- Reset asserted mid-stream:
  - all pending busy bits are discarded;
  - any write presented in the reset cycle is lost.
- No back-pressure: one write, one issue and one read-pair are accepted every cycle unconditionally.

## Structure
- Shared package constants:
  - XLEN, AW, NREGS;
  - REG_ZERO = 5'd0;
  - a register-index type of width AW.
- Sub-module regfile_scoreboard contains:
  - the busy vector;
  - the set/clear priority logic;
  - the two combinational busy lookups with the write-clear bypass.
- regfile holds the data array, the read capture registers and the forward muxes.

## Test plan
- Reset then read: assert reset 1 cycle, read sel1=5, sel2=31 with en=1 -> both data outputs 0 next cycle, busy1=busy2=0.
- Write then read: write x3=0xDEADBEEF, next cycle read sel1=3 -> io_read_data1=0xDEADBEEF one cycle later. Write x0=0x1234, read sel2=0 -> 0.
- Forwarding: in the same cycle write x7=0xA5A5A5A5 and read sel1=7, sel2=7 with en=1 -> both outputs 0xA5A5A5A5 next cycle.
- Read hold: capture x3 with en=1, then write x3=0x1 with en=0 for 3 cycles -> data1 holds 0xDEADBEEF.
- Scoreboard basic:
  - issue x10; next cycle sel1=10 -> busy1=1;
  - write x10 -> busy1=0 in that same cycle, and 0 afterwards.
  - Issue x0 -> busy stays 0.
- Scoreboard collision:
  - busy[12]=1, then issue x12 and write x12 in the same cycle -> busy1 (sel1=12) is 0 in that cycle, 1 in the next;
  - a later write x12 -> 0.
  - Assert reset with busy[4]=1 -> busy cleared.
